// File: rtl/sprite_pkg.sv
// Shared types and helpers for the animated sprite-sheet ROM.
package sprite_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, DONE} anim_state_t;

  localparam int unsigned PIX_W_DEFAULT = 12;

  function automatic int unsigned mirror_idx(input int unsigned idx, input int unsigned size);
    return size - 1 - idx;
  endfunction

endpackage

// File: rtl/anim_sequencer.sv
// Play / loop / one-shot frame sequencer stepped by an external animation tick.
module anim_sequencer
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_FRAMES = 4,
  localparam int unsigned FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          anim_start,
  input  logic          anim_tick,
  input  logic          anim_loop,
  output logic [FW-1:0] frame,
  output logic          anim_busy,
  output logic          anim_done
);

  localparam logic [FW-1:0] LastFrame = FW'(NUM_FRAMES - 1);

  anim_state_t   state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    // Start has priority over a coincident tick.
    if (anim_start) begin
      frame_d = '0;
      state_d = PLAY;
    end else if (anim_tick && state_q == PLAY) begin
      if (frame_q == LastFrame) begin
        if (anim_loop) begin
          frame_d = '0;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  assign frame     = frame_q;
  assign anim_busy = (state_q == PLAY);
  assign anim_done = done_q;

endmodule

// File: rtl/sprite_sheet_rom.sv
// Multi-frame sprite ROM with mirroring, a 2-stage read pipeline and transparency flag.
module sprite_sheet_rom
  import sprite_pkg::*;
#(
  parameter                    FILENAME    = "p1_sheet.mem",
  parameter int unsigned       SPR_W       = 128,
  parameter int unsigned       SPR_H       = 128,
  parameter int unsigned       NUM_FRAMES  = 4,
  parameter int unsigned       PIX_W       = PIX_W_DEFAULT,
  parameter logic [PIX_W-1:0]  TRANSPARENT = '0,
  localparam int unsigned      XW          = $clog2(SPR_W),
  localparam int unsigned      YW          = $clog2(SPR_H),
  localparam int unsigned      FW          = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [XW-1:0]    x,
  input  logic [YW-1:0]    y,
  input  logic             reverse,
  input  logic             vflip,
  input  logic             anim_start,
  input  logic             anim_tick,
  input  logic             anim_loop,
  output logic [FW-1:0]    frame,
  output logic             anim_busy,
  output logic             anim_done,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pixel_data,
  output logic             pix_transparent
);

  localparam int unsigned FrameWords = SPR_W * SPR_H;
  localparam int unsigned Depth      = NUM_FRAMES * FrameWords;
  localparam int unsigned AW         = $clog2(Depth);

  logic [XW-1:0]    col;
  logic [YW-1:0]    row;
  logic [AW-1:0]    addr_d, addr_q;
  logic             req_q;
  logic [PIX_W-1:0] rom [Depth];

  anim_sequencer #(
    .NUM_FRAMES (NUM_FRAMES)
  ) u_seq (
    .clk        (clk),
    .reset      (reset),
    .anim_start (anim_start),
    .anim_tick  (anim_tick),
    .anim_loop  (anim_loop),
    .frame      (frame),
    .anim_busy  (anim_busy),
    .anim_done  (anim_done)
  );

  // Frame base is a constant multiply; row/col are power-of-two fields concatenated.
  always_comb begin
    col    = reverse ? XW'(mirror_idx(32'(x), SPR_W)) : x;
    row    = vflip   ? YW'(mirror_idx(32'(y), SPR_H)) : y;
    addr_d = AW'(32'(frame) * FrameWords) + AW'({row, col});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= 1'b0;
    end else begin
      req_q <= req_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (req_valid) begin
      addr_q <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid       <= 1'b0;
      pixel_data      <= '0;
      pix_transparent <= 1'b0;
    end else begin
      pix_valid <= req_q;
      if (req_q) begin
        pixel_data      <= rom[addr_q];
        pix_transparent <= (rom[addr_q] == TRANSPARENT);
      end
    end
  end

endmodule
